hallway_tracer_array: RTL
=========================

Name: hallway_tracer_array

Overview:
- Generalised tracer datapath: NUM_TRACERS independent hallway tracers, each a bounded vertical position register with a direction bit.
- Adds per-lane bounds derived from parameters, a minimum-gap rule between adjacent tracers, an internal parametrised LFSR for random direction reversals, and per-tracer reversal pulses.
- Sits between the game FSM (which supplies gameTick) and the hallway renderer and collision logic (which consume positions).
- Replaces the external inc/dec control of the fixed two-tracer version: motion is self-timed on gameTick.

Parameters:
- NUM_TRACERS, 2, number of tracers; index 0 is topmost (smallest y). Range 1..8.
- POS_WIDTH, 7, bit width of each position.
- LANE_OFFSET, 26, lower bound of lane i = i*LANE_OFFSET.
- LANE_RANGE, 93, upper bound of lane i = i*LANE_OFFSET + LANE_RANGE.
- INIT_BASE, 40, reset position of tracer 0.
- INIT_STEP, 40, reset position of tracer i = INIT_BASE + i*INIT_STEP.
- MIN_GAP, 20, minimum allowed pos[i+1]-pos[i].
- LFSR_WIDTH, 16, Fibonacci LFSR width (taps 16,14,13,11 at default).
- SEED, 16'hACE1, LFSR reset/reseed value; must be nonzero.
- RAND_BITS, 4, random reversal probability 1/2^RAND_BITS per tick; NUM_TRACERS*RAND_BITS must be <= LFSR_WIDTH.

Ports:
- clock  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- gameTick  in  1  one-cycle update strobe.
- resetNumberGenerator  in  1  synchronous LFSR reseed to SEED.
- tracerPos  out  NUM_TRACERS*POS_WIDTH  packed positions; tracer i at [i*POS_WIDTH +: POS_WIDTH].
- tracerDir  out  NUM_TRACERS  per-tracer direction: 0 = up (y decreasing), 1 = down.
- tracerBounce  out  NUM_TRACERS  one-cycle pulse when that tracer reversed on the preceding tick.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-low on reset_n.
- Reset values:
  - pos[i] = INIT_BASE + i*INIT_STEP.
  - dir = all 0.
  - tracerBounce = 0.
  - LFSR = SEED.
- Reset mid-operation restores all reset values immediately, regardless of any tick in progress.
- LFSR:
  - Advances one step on each clock with gameTick=1.
  - resetNumberGenerator=1 loads SEED and has priority over advancing.
  - rnd[i] = (lfsr[i*RAND_BITS +: RAND_BITS] == 0), sampled from the pre-advance value.
- Update timing: on a clock edge with gameTick=1, every tracer evaluates simultaneously from the current registered state. Results are visible the cycle after the tick, so latency is 1.
- With gameTick=0:
  - pos, dir and LFSR hold.
  - tracerBounce returns to 0.
- Per-tracer decision, first match wins:
  1. At bound: dir=0 and pos==lower bound, or dir=1 and pos==upper bound -> reverse, no move.
  2. Gap-blocked: moving toward a neighbour and (gap - approach) < MIN_GAP -> reverse, no move.
     - gap = |pos[nbr]-pos[i]|.
     - approach = 2 if the neighbour is also moving toward i and is not itself reversing under rule 1, else 1.
     - Tracer 0 has no upper neighbour; tracer N-1 has no lower neighbour.
  3. Random: rnd[i] -> reverse, no move.
  4. Otherwise move by one: pos+1 if dir=1, pos-1 if dir=0.
- tracerBounce[i] = 1 for exactly the cycle after any reversal of tracer i; 0 otherwise.
- Invariants, which must hold every cycle after reset:
  - lower bound <= pos[i] <= upper bound.
  - pos[i+1]-pos[i] >= MIN_GAP, provided the reset values satisfy it.
  - No arithmetic wrap: bound checks precede the move, so no increment or decrement past 0 or 2^POS_WIDTH-1.
- Bound arithmetic is computed at elaboration in POS_WIDTH+1 bits. Elaboration fails if:
  - (NUM_TRACERS-1)*LANE_OFFSET + LANE_RANGE >= 2^POS_WIDTH, or
  - the reset gap is below MIN_GAP.
- NUM_TRACERS=1: only bound and random rules apply.

Test Plan:
- Reset at defaults -> tracerPos = {7'd80, 7'd40}, tracerDir = 2'b00, tracerBounce = 0. After 1 tick with no random hit -> positions 39 and 79.
- Force LFSR to never hit (RAND_BITS covers a nonzero slice; hold resetNumberGenerator on a seed whose slices are nonzero) and drive 40 ticks from reset:
  - tracer 0 reaches 0 on tick 40.
  - tick 41 -> dir[0]=1, pos stays 0, bounce[0] pulses 1 cycle.
  - tick 42 -> pos 1.
- Gap rule: force pos {60, 39} with dirs {0, 1} (converging, gap 21) -> one tick yields gap 21-2=19 < 20, so both reverse. Positions unchanged, both bounce bits pulse.
- Random reversal: SEED chosen so slice 0 is 0000 at the first tick -> tracer 0 reverses without moving; tracer 1 moves normally.
- resetNumberGenerator asserted together with gameTick -> LFSR equals SEED next cycle. The repeated tick sequence reproduces an identical position trace.
- NUM_TRACERS=4, POS_WIDTH=8, LANE_OFFSET=40, LANE_RANGE=100, INIT_STEP=40:
  - run 10,000 random ticks with reset_n pulsed mid-run.
  - Assert bounds and MIN_GAP invariants every cycle.
  - Assert all regs equal reset values in the same cycle reset_n falls.

Source files
------------

// File: rtl/hallway_tracer_array.sv
// Array of self-timed hallway tracers: bounded per-lane positions, minimum spacing
// between neighbours, and LFSR-driven random direction reversals on each gameTick.
module hallway_tracer_array #(
    parameter int                    NUM_TRACERS = 2,
    parameter int                    POS_WIDTH   = 7,
    parameter int                    LANE_OFFSET = 26,
    parameter int                    LANE_RANGE  = 93,
    parameter int                    INIT_BASE   = 40,
    parameter int                    INIT_STEP   = 40,
    parameter int                    MIN_GAP     = 20,
    parameter int                    LFSR_WIDTH  = 16,
    parameter logic [LFSR_WIDTH-1:0] SEED        = 16'hACE1,
    parameter logic [LFSR_WIDTH-1:0] LFSR_TAPS   = 16'hB400,
    parameter int                    RAND_BITS   = 4
) (
    input  logic                             clock,
    input  logic                             reset_n,
    input  logic                             gameTick,
    input  logic                             resetNumberGenerator,
    output logic [NUM_TRACERS*POS_WIDTH-1:0] tracerPos,
    output logic [NUM_TRACERS-1:0]           tracerDir,
    output logic [NUM_TRACERS-1:0]           tracerBounce
);

    localparam int TOP_BOUND = (NUM_TRACERS - 1) * LANE_OFFSET + LANE_RANGE;

    if (TOP_BOUND >= (1 << POS_WIDTH)) begin : g_err_bound
        $error("hallway_tracer_array: lane bounds exceed POS_WIDTH");
    end
    if (NUM_TRACERS > 1 && INIT_STEP < MIN_GAP) begin : g_err_gap
        $error("hallway_tracer_array: reset spacing below MIN_GAP");
    end
    if (NUM_TRACERS * RAND_BITS > LFSR_WIDTH) begin : g_err_rand
        $error("hallway_tracer_array: LFSR too narrow for random slices");
    end
    if (SEED == '0) begin : g_err_seed
        $error("hallway_tracer_array: SEED must be nonzero");
    end

    function automatic logic [POS_WIDTH-1:0] init_pos(input int idx);
        return POS_WIDTH'(INIT_BASE + idx * INIT_STEP);
    endfunction

    // True when stepping toward the neighbour would leave less than MIN_GAP;
    // a closing neighbour that will also move shrinks the gap by two.
    function automatic logic too_close(input logic [POS_WIDTH-1:0] p_self,
                                       input logic [POS_WIDTH-1:0] p_nbr,
                                       input logic                 closing);
        int gap;
        int approach;
        gap      = int'(p_nbr) - int'(p_self);
        if (gap < 0) gap = -gap;
        approach = closing ? 2 : 1;
        return (gap < MIN_GAP + approach);
    endfunction

    logic [POS_WIDTH-1:0]   pos      [NUM_TRACERS];
    logic [POS_WIDTH-1:0]   pos_next [NUM_TRACERS];
    logic [NUM_TRACERS-1:0] dir;
    logic [NUM_TRACERS-1:0] bounce;
    logic [LFSR_WIDTH-1:0]  lfsr;

    logic [NUM_TRACERS-1:0] at_bound;
    logic [NUM_TRACERS-1:0] rnd;
    logic [NUM_TRACERS-1:0] blk_up;
    logic [NUM_TRACERS-1:0] blk_dn;
    logic [NUM_TRACERS-1:0] reverse;

    for (genvar g = 0; g < NUM_TRACERS; g++) begin : g_tracer
        localparam int                   LO_I = g * LANE_OFFSET;
        localparam int                   HI_I = g * LANE_OFFSET + LANE_RANGE;
        localparam logic [POS_WIDTH:0]   LO_W = LO_I[POS_WIDTH:0];
        localparam logic [POS_WIDTH:0]   HI_W = HI_I[POS_WIDTH:0];
        localparam logic [POS_WIDTH-1:0] LO   = LO_W[POS_WIDTH-1:0];
        localparam logic [POS_WIDTH-1:0] HI   = HI_W[POS_WIDTH-1:0];

        assign at_bound[g] = dir[g] ? (pos[g] == HI) : (pos[g] == LO);
        assign rnd[g]      = (lfsr[g*RAND_BITS +: RAND_BITS] == '0);

        // Moving up (dir=0) approaches tracer g-1; moving down approaches g+1.
        if (g > 0) begin : g_up
            assign blk_up[g] = too_close(pos[g], pos[g-1], dir[g-1] & ~at_bound[g-1]);
        end else begin : g_no_up
            assign blk_up[g] = 1'b0;
        end
        if (g < NUM_TRACERS - 1) begin : g_dn
            assign blk_dn[g] = too_close(pos[g], pos[g+1], ~dir[g+1] & ~at_bound[g+1]);
        end else begin : g_no_dn
            assign blk_dn[g] = 1'b0;
        end

        assign reverse[g]  = at_bound[g] | (dir[g] ? blk_dn[g] : blk_up[g]) | rnd[g];
        assign pos_next[g] = reverse[g] ? pos[g]
                           : (dir[g] ? pos[g] + 1'b1 : pos[g] - 1'b1);

        assign tracerPos[g*POS_WIDTH +: POS_WIDTH] = pos[g];
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NUM_TRACERS; i++) begin
                pos[i] <= init_pos(i);
            end
            dir    <= '0;
            bounce <= '0;
            lfsr   <= SEED;
        end else begin
            bounce <= '0;
            if (gameTick) begin
                for (int i = 0; i < NUM_TRACERS; i++) begin
                    pos[i] <= pos_next[i];
                end
                dir    <= dir ^ reverse;
                bounce <= reverse;
            end
            // Fibonacci LFSR shifting toward the MSB; reseed wins over advance.
            if (resetNumberGenerator) begin
                lfsr <= SEED;
            end else if (gameTick) begin
                lfsr <= {lfsr[LFSR_WIDTH-2:0], ^(lfsr & LFSR_TAPS)};
            end
        end
    end

    assign tracerDir    = dir;
    assign tracerBounce = bounce;

endmodule
